pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register for the lc3b pipeline. It replaces the fixed-field, load-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. The block carries an opaque payload of WIDTH bits, uses a valid/ready handshake on both sides, and supports flush (bubble insertion). It keeps a saturating back-pressure counter for performance analysis. One instance sits between each pair of adjacent stages.

## Interface
- WIDTH, 64: payload width in bits; legal range 1 to 1024.
- CNT_WIDTH, 16: width of the stall counter; legal range 1 to 32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream stage offers a beat.
- in_ready  out  1  this stage accepts the beat this cycle.
- in_data  in  WIDTH  upstream payload (control word, IR, PC, ALU result, dest, …).
- flush  in  1  kill all held and incoming beats.
- out_valid  out  1  downstream payload is valid.
- out_ready  in  1  downstream stage consumes the beat this cycle.
- out_data  out  WIDTH  held payload.
- clr_count  in  1  synchronous clear of stall_count.
- stall_count  out  CNT_WIDTH  cycles spent with out_valid=1 and out_ready=0.

## Operation
- Accept condition: in_valid & in_ready. Release condition: out_valid & out_ready.
- Main entry holds {main_valid, main_data}. out_valid is main_valid and out_data is main_data.
- Base mode (no skid):
  - in_ready = out_ready | ~main_valid (combinational).
  - When in_ready=1, main loads {in_valid, in_data}.
  - Otherwise main holds.
- Flush has priority over all other actions:
  - On the next edge every valid bit is cleared.
  - A beat accepted in the flush cycle is dropped.
  - in_ready keeps its normal value during flush, so upstream sees the beat as consumed.
  - Data registers may load but are don't-care while their valid bit is 0.
- Stall counter:
  - Increments when out_valid & ~out_ready.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - clr_count sets it to 0 and takes priority over increment.
  - flush does not affect the counter.
- Payload is opaque. No field is interpreted, and no width conversion or padding is applied.

## Timing
- Reset values: out_valid=0, out_data=0, stall_count=0, skid entry empty.
- in_ready after reset: 1 in both modes. In base mode this follows from main_valid=0.
- Latency: a beat accepted at edge N is presented on out_* from edge N onward, i.e. it is visible in the cycle after acceptance.
- Throughput: 1 beat/cycle sustained when out_ready=1.
- Data must not change while out_valid=1 & out_ready=0.
- Simultaneous release and accept in the same cycle: the new beat replaces the old one, with no bubble.
- Reset asserted mid-stream: all state clears immediately (asynchronous). In-flight beats are lost, and that is accepted.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - A second skid entry {skid_valid, skid_data} is added.
  - in_ready = ~skid_valid, taken from a flop; there is no combinational path from out_ready to in_ready.
  - Beat accepted while main is valid and not released: the beat goes to skid.
  - Main released while skid is valid: skid moves to main and skid empties.
  - Main empty or being released, with skid empty: the incoming beat goes directly to main.
  - Ordering is strictly FIFO. At most 2 beats are held.
  - flush clears both valid bits.
- PIPE_STAGE_SKID_EN undefined: base mode only, with no skid flops.
- Ports and parameters are identical in both builds.

## Structure
- These definitions belong in lc3b_types:
  - Per-stage payload packed structs (lc3b_if_id_t, lc3b_id_ex_t, lc3b_ex_mem_t, lc3b_mem_wb_t) built from lc3b_word, lc3b_control and lc3b_reg.
  - Instances set WIDTH=$bits(<struct>).
- The stall-counter saturation width default lives in the package as constant LC3B_STALL_CNT_W.
- One sub-module is natural: pipe_sat_counter (CNT_WIDTH, inc, clr, count). It is reused by other performance counters.
- The skid logic stays inline under the macro.

## Test plan
- Reset then stream 0x1, 0x2, 0x3 with out_ready=1: out_data is 0x1, 0x2, 0x3 on consecutive cycles, and stall_count stays 0.
- Back-pressure: hold beat 0xAA, set out_ready=0 for 5 cycles, then 1.
  - out_data stays 0xAA and stall_count=5.
  - Base mode: in_ready=0 for those 5 cycles.
  - Skid mode: one extra beat 0xBB is accepted; it then drains in order 0xAA then 0xBB with no loss.
- Flush while holding 0x55, with in_valid=1 and in_data=0x66 in the same cycle: out_valid=0 on the next cycle, and neither 0x55 nor 0x66 ever appears.
- Saturation, with CNT_WIDTH=3: out_ready=0 for 10 cycles gives stall_count=7. clr_count asserted together with a stall cycle gives 0.
- Asynchronous reset between clock edges while valid: out_valid and stall_count go to 0 immediately, before the next edge, and in_ready=1.
- Random valid/ready with flush rate 5% against a scoreboard: output equals the accepted beats minus flushed beats, in order, in both macro builds.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared lc3b pipeline types: per-stage payload structs and the stall counter default width.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] aluop;
      logic       load_regfile;
      logic       load_cc;
      logic       mem_read;
      logic       mem_write;
      logic       br_en;
      logic [1:0] pcmux_sel;
      logic [1:0] regfilemux_sel;
   } lc3b_control;

   typedef struct packed {
      lc3b_word pc;
      lc3b_word ir;
   } lc3b_if_id_t;

   typedef struct packed {
      lc3b_control ctrl;
      lc3b_word    pc;
      lc3b_word    ir;
      lc3b_word    sr1_data;
      lc3b_word    sr2_data;
      lc3b_reg     dest;
   } lc3b_id_ex_t;

   typedef struct packed {
      lc3b_control ctrl;
      lc3b_word    pc;
      lc3b_word    alu_out;
      lc3b_word    sr2_data;
      lc3b_reg     dest;
   } lc3b_ex_mem_t;

   typedef struct packed {
      lc3b_control ctrl;
      lc3b_word    pc;
      lc3b_word    alu_out;
      lc3b_word    mem_rdata;
      lc3b_reg     dest;
   } lc3b_mem_wb_t;

   localparam int unsigned LC3B_STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_stage_reg_counter.sv
// pipe_sat_counter: saturating event counter with synchronous clear; shared by performance counters.
module pipe_sat_counter
   import lc3b_types::*;
#(
   parameter int CNT_WIDTH = LC3B_STALL_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] count
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] count_r;
   logic [CNT_WIDTH-1:0] count_nx_s;

   // next count: clear wins over increment, increment stops at the maximum
   always_comb begin
      count_nx_s = count_r;
      if (clr) begin
         count_nx_s = {CNT_WIDTH{1'b0}};
      end else if (inc && (count_r != CNT_MAX)) begin
         count_nx_s = count_r + CNT_ONE;
      end else begin
         count_nx_s = count_r;
      end
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CNT_WIDTH{1'b0}};
      end else begin
         count_r <= count_nx_s;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry that registers in_ready.
module pipe_stage_reg
   import lc3b_types::*;
#(
   parameter int WIDTH     = 64,
   parameter int CNT_WIDTH = LC3B_STALL_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 clr_count,
   output logic [CNT_WIDTH-1:0] stall_count
);

   logic             main_valid_r;
   logic [WIDTH-1:0] main_data_r;
   logic             main_valid_nx_s;
   logic [WIDTH-1:0] main_data_nx_s;
   logic             in_ready_s;

`ifdef PIPE_STAGE_SKID_EN
   logic             skid_valid_r;
   logic [WIDTH-1:0] skid_data_r;
   logic             skid_valid_nx_s;
   logic [WIDTH-1:0] skid_data_nx_s;
   logic             accept_s;
   logic             release_s;

   assign in_ready_s = ~skid_valid_r;
   assign accept_s   = in_valid & in_ready_s;
   assign release_s  = main_valid_r & out_ready;

   // two-entry FIFO steering: skid refills main first, else input goes straight to main
   always_comb begin
      main_valid_nx_s = main_valid_r;
      main_data_nx_s  = main_data_r;
      skid_valid_nx_s = skid_valid_r;
      skid_data_nx_s  = skid_data_r;
      if (!main_valid_r || release_s) begin
         if (skid_valid_r) begin
            main_valid_nx_s = 1'b1;
            main_data_nx_s  = skid_data_r;
            skid_valid_nx_s = 1'b0;
         end else begin
            main_valid_nx_s = accept_s;
            main_data_nx_s  = in_data;
         end
      end else if (accept_s) begin
         skid_valid_nx_s = 1'b1;
         skid_data_nx_s  = in_data;
      end else begin
         skid_valid_nx_s = skid_valid_r;
      end
      if (flush) begin
         main_valid_nx_s = 1'b0;
         skid_valid_nx_s = 1'b0;
      end else begin
         main_valid_nx_s = main_valid_nx_s;
      end
   end

   // skid entry registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid_r <= 1'b0;
         skid_data_r  <= {WIDTH{1'b0}};
      end else begin
         skid_valid_r <= skid_valid_nx_s;
         skid_data_r  <= skid_data_nx_s;
      end
   end
`else
   assign in_ready_s = out_ready | ~main_valid_r;

   // single entry: load whenever ready, flush drops whatever was held or accepted
   always_comb begin
      main_valid_nx_s = main_valid_r;
      main_data_nx_s  = main_data_r;
      if (in_ready_s) begin
         main_valid_nx_s = in_valid;
         main_data_nx_s  = in_data;
      end else begin
         main_valid_nx_s = main_valid_r;
      end
      if (flush) begin
         main_valid_nx_s = 1'b0;
      end else begin
         main_valid_nx_s = main_valid_nx_s;
      end
   end
`endif

   // main entry registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {WIDTH{1'b0}};
      end else begin
         main_valid_r <= main_valid_nx_s;
         main_data_r  <= main_data_nx_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = main_valid_r;
   assign out_data  = main_data_r;

   pipe_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (main_valid_r & ~out_ready),
      .clr   (clr_count),
      .count (stall_count)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps plus random traffic against a queue-based model.
module tb_pipe_stage_reg;

   localparam int W    = 16;
   localparam int CW   = 3;
   localparam int CMAX = 7;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          clr_count;
   logic [CW-1:0] stall_count;

   int checks = 0;
   int errors = 0;

   // model: beats currently held by the stage, oldest first
   logic [W-1:0] q[$];
   int           stall_m = 0;

   pipe_stage_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .clr_count   (clr_count),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_ready(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || ordy;
`endif
   endfunction

   // one clock: drive, compare against the model mid-cycle, advance model at the edge
   task automatic do_cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                           input logic fl, input logic clr);
      logic rdy;
      logic acc;
      logic rel;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      clr_count = clr;
      @(negedge clk);
      rdy = model_ready(ordy);
      check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      check("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
      if (q.size() > 0) check("out_data", {16'd0, out_data}, {16'd0, q[0]});
      check("stall_count", {29'd0, stall_count}, stall_m);
      acc = iv && rdy;
      rel = (q.size() > 0) && ordy;
      if (clr) stall_m = 0;
      else if ((q.size() > 0) && !ordy && (stall_m < CMAX)) stall_m++;
      if (fl) begin
         q.delete();
      end else begin
         if (rel) void'(q.pop_front());
         if (acc) q.push_back(id);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; flush = 1'b0;
      out_ready = 1'b0; clr_count = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_stall", {29'd0, stall_count}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // stream 1,2,3 at full rate
      do_cycle(1'b1, 16'h1, 1'b1, 1'b0, 1'b0);
      check("stream_1", {16'd0, out_data}, 32'h1);
      do_cycle(1'b1, 16'h2, 1'b1, 1'b0, 1'b0);
      check("stream_2", {16'd0, out_data}, 32'h2);
      do_cycle(1'b1, 16'h3, 1'b1, 1'b0, 1'b0);
      check("stream_3", {16'd0, out_data}, 32'h3);
      check("stream_stall", {29'd0, stall_count}, 32'd0);
      do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

      // back-pressure: hold 0xAA for 5 cycles, offer 0xBB once
      do_cycle(1'b1, 16'hAA, 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1, 16'hBB, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) do_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("bp_data", {16'd0, out_data}, 32'hAA);
      check("bp_stall", {29'd0, stall_count}, 32'd5);
      do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
      check("bp_skid_drain", {16'd0, out_data}, 32'hBB);
      check("bp_skid_valid", {31'd0, out_valid}, 32'd1);
`else
      check("bp_base_empty", {31'd0, out_valid}, 32'd0);
`endif
      do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

      // flush while holding 0x55 with 0x66 offered
      do_cycle(1'b1, 16'h55, 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1, 16'h66, 1'b0, 1'b1, 1'b0);
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

      // saturation at 7 and clear-over-increment
      do_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      do_cycle(1'b1, 16'h77, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) do_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("sat_stall", {29'd0, stall_count}, 32'd7);
      do_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("clr_stall", {29'd0, stall_count}, 32'd0);
      do_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      // asynchronous reset between edges while valid
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_stall", {29'd0, stall_count}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      q.delete();
      stall_m = 0;

      // random traffic with ~5% flush
      for (int i = 0; i < 600; i++) begin
         do_cycle(($urandom_range(0, 99) < 60),
                  W'($urandom),
                  ($urandom_range(0, 99) < 65),
                  ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 99) < 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
